vector_bank_ctrl: RTL and testbench

//  Ping-pong (double-buffered) vector-list controller between the scene generator and
//  top_vector_display. Writer fills the back bank while the display redraws the front

---
 rtl/vector_pkg.sv | 12 +
 rtl/vector_bank_ram.sv | 29 ++
 rtl/vector_bank_ctrl.sv | 101 ++++++++++
 tb/tb_vector_bank_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the double-buffered vector-list controller.
package vector_pkg;

  localparam int VEC_WORD_W = 18;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_FILLING,
    BANK_PENDING
  } bank_state_t;

endpackage

// File: rtl/vector_bank_ram.sv
// One vector-list bank: single write port, synchronous read port.
module vector_bank_ram
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = VEC_WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]    rd_data
);

  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRESSWIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_bank_ctrl.sv
// Ping-pong vector-list controller: writer fills the back bank, display reads the
// front bank, and a committed frame is swapped in only on the display's frame_drawn.
module vector_bank_ctrl
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = VEC_WORD_W,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic                    wr_commit,
  output logic                    wr_ready,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]    rd_data,
  input  logic                    frame_drawn,
  output logic                    disp_enable,
  output logic                    swap,
  output logic                    front_sel,
  output logic [CNT_WIDTH-1:0]    repeat_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  bank_state_t          state;
  logic                 wr_fire;
  logic                 we0;
  logic                 we1;
  logic                 rd_sel;
  logic [DATAWIDTH-1:0] q0;
  logic [DATAWIDTH-1:0] q1;

  assign wr_ready = (state != BANK_PENDING);
  assign wr_fire  = wr_en && wr_ready;
  assign we0      = wr_fire && front_sel;
  assign we1      = wr_fire && !front_sel;

  vector_bank_ram #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (we0),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (q0)
  );

  vector_bank_ram #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (we1),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (q1)
  );

  // The select follows the bank data by one cycle so a read issued in the
  // swap-trigger cycle still returns the old front bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_sel <= 1'b0;
    else      rd_sel <= front_sel;
  end

  assign rd_data = rd_sel ? q1 : q0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BANK_IDLE;
      front_sel   <= 1'b0;
      disp_enable <= 1'b0;
      swap        <= 1'b0;
      repeat_cnt  <= '0;
    end else begin
      swap <= 1'b0;
      case (state)
        BANK_IDLE, BANK_FILLING: begin
          if (wr_commit)  state <= BANK_PENDING;
          else if (wr_en) state <= BANK_FILLING;
          // A redraw without a swap counts as a repeat of the current frame.
          if (frame_drawn && disp_enable && (repeat_cnt != CNT_MAX))
            repeat_cnt <= repeat_cnt + 1'b1;
        end
        BANK_PENDING: begin
          if (frame_drawn) begin
            front_sel   <= ~front_sel;
            swap        <= 1'b1;
            disp_enable <= 1'b1;
            repeat_cnt  <= '0;
            state       <= BANK_IDLE;
          end
        end
        default: state <= BANK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_bank_ctrl.sv
// Scoreboard bench for vector_bank_ctrl: stimulus queues expectations, a monitor checks them.
module tb_vector_bank_ctrl;

  localparam int K_WR_READY = 0;
  localparam int K_DISP     = 1;
  localparam int K_FRONT    = 2;
  localparam int K_REPEAT   = 3;
  localparam int K_RD_DATA  = 4;
  localparam int K_SWAP     = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [17:0] wr_data;
  logic        wr_commit;
  logic        wr_ready;
  logic [7:0]  rd_addr;
  logic [17:0] rd_data;
  logic        frame_drawn;
  logic        disp_enable;
  logic        swap;
  logic        front_sel;
  logic [7:0]  repeat_cnt;

  chk_t chk_q[$];
  logic swap_q[$];
  int   cycle;
  int   pass_cnt;
  int   total_cnt;

  vector_bank_ctrl #(.ADDRESSWIDTH(8), .DATAWIDTH(18), .CNT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_commit   (wr_commit),
    .wr_ready    (wr_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_drawn (frame_drawn),
    .disp_enable (disp_enable),
    .swap        (swap),
    .front_sel   (front_sel),
    .repeat_cnt  (repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_actual(input int kind);
    case (kind)
      K_WR_READY: return {31'b0, wr_ready};
      K_DISP:     return {31'b0, disp_enable};
      K_FRONT:    return {31'b0, front_sel};
      K_REPEAT:   return {24'b0, repeat_cnt};
      K_RD_DATA:  return {14'b0, rd_data};
      default:    return {31'b0, swap};
    endcase
  endfunction

  task automatic check_output(input int ahead, input int kind, input logic [31:0] exp,
                              input string name);
    chk_t c;
    c.cyc  = cycle + ahead;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic apply_stimulus(input logic we, input logic [7:0] addr, input logic [17:0] data,
                                input logic commit, input logic fd, input logic [7:0] ra);
    wr_en       = we;
    wr_addr     = addr;
    wr_data     = data;
    wr_commit   = commit;
    frame_drawn = fd;
    rd_addr     = ra;
    @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
      #2;
      for (int i = 0; i < chk_q.size(); ) begin
        if (chk_q[i].cyc <= cycle) begin
          logic [31:0] act;
          act = get_actual(chk_q[i].kind);
          total_cnt = total_cnt + 1;
          if (act === chk_q[i].exp) pass_cnt = pass_cnt + 1;
          else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", chk_q[i].name, act, chk_q[i].exp);
          chk_q.delete(i);
        end else begin
          i++;
        end
      end
      if (swap === 1'b1) begin
        total_cnt = total_cnt + 1;
        if (swap_q.size() == 0) begin
          $display("[TB] FAIL unexpected_swap: got swap=1 front_sel=%0b, want no swap", front_sel);
        end else begin
          logic exp_front;
          exp_front = swap_q.pop_front();
          if (front_sel === exp_front && disp_enable === 1'b1) pass_cnt = pass_cnt + 1;
          else $display("[TB] FAIL swap_event: got front_sel=%0b disp=%0b, want front_sel=%0b disp=1",
                        front_sel, disp_enable, exp_front);
        end
      end
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
    frame_drawn = 1'b0; rd_addr = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output(1, K_RD_DATA, 32'h0, "reset_rd_data");
    check_output(1, K_SWAP, 32'h0, "reset_swap");
    apply_stimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Test 1: post-reset idle state
    check_output(1, K_WR_READY, 32'h1, "t1_wr_ready");
    check_output(1, K_DISP, 32'h0, "t1_disp_enable");
    check_output(1, K_FRONT, 32'h0, "t1_front_sel");
    check_output(1, K_REPEAT, 32'h0, "t1_repeat_cnt");
    apply_stimulus(0, 0, 0, 0, 0, 0);

    // Test 2/3: write, commit, ignored write while pending, swap
    apply_stimulus(1, 8'd5, 18'h3A5F0, 0, 0, 8'd5);
    check_output(1, K_WR_READY, 32'h0, "t2_pending_wr_ready");
    apply_stimulus(0, 0, 0, 1, 0, 8'd5);
    check_output(1, K_WR_READY, 32'h0, "t3_pending_hold");
    apply_stimulus(1, 8'd5, 18'h00001, 1, 0, 8'd5);
    swap_q.push_back(1'b1);
    check_output(1, K_SWAP, 32'h1, "t2_swap_high");
    check_output(1, K_FRONT, 32'h1, "t2_front_sel");
    check_output(1, K_DISP, 32'h1, "t2_disp_enable");
    check_output(1, K_WR_READY, 32'h1, "t2_wr_ready_after");
    check_output(2, K_SWAP, 32'h0, "t2_swap_one_cycle");
    check_output(2, K_RD_DATA, 32'h3A5F0, "t3_rd_data_kept");
    apply_stimulus(0, 0, 0, 0, 1, 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 8'd5);

    // Test 4: commit and frame_drawn together defer the swap
    apply_stimulus(1, 8'd5, 18'h11111, 0, 0, 8'd5);
    check_output(1, K_FRONT, 32'h1, "t4_no_swap_front");
    check_output(1, K_WR_READY, 32'h0, "t4_pending");
    apply_stimulus(0, 0, 0, 1, 1, 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 8'd5);
    swap_q.push_back(1'b0);
    check_output(1, K_FRONT, 32'h0, "t4_front_sel");
    check_output(1, K_RD_DATA, 32'h3A5F0, "t4_trigger_old_bank");
    check_output(1, K_REPEAT, 32'h0, "t4_repeat_cleared");
    check_output(2, K_RD_DATA, 32'h11111, "t4_new_bank");
    apply_stimulus(0, 0, 0, 0, 1, 8'd5);
    apply_stimulus(0, 0, 0, 0, 0, 8'd5);

    // Test 5: repeat counter saturation
    for (int i = 1; i <= 300; i++) begin
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check_output(1, K_REPEAT, (i < 255) ? i : 255, "t5_repeat_cnt");
      apply_stimulus(0, 0, 0, 0, 1, 8'd0);
      apply_stimulus(0, 0, 0, 0, 0, 8'd0);
    end
    check_output(1, K_FRONT, 32'h0, "t5_front_unchanged");
    apply_stimulus(0, 0, 0, 1, 0, 8'd0);
    check_output(1, K_REPEAT, 32'd255, "t5_repeat_held_pending");
    apply_stimulus(0, 0, 0, 0, 0, 8'd0);
    swap_q.push_back(1'b1);
    check_output(1, K_REPEAT, 32'h0, "t5_repeat_reset");
    check_output(1, K_FRONT, 32'h1, "t5_front_sel");
    apply_stimulus(0, 0, 0, 0, 1, 8'd0);
    apply_stimulus(0, 0, 0, 0, 0, 8'd0);

    // Test 6: reset while pending loses the commit
    check_output(1, K_WR_READY, 32'h0, "t6_pending");
    apply_stimulus(0, 0, 0, 1, 0, 8'd0);
    rst = 1'b0;
    check_output(1, K_WR_READY, 32'h1, "t6_rst_wr_ready");
    check_output(1, K_FRONT, 32'h0, "t6_rst_front_sel");
    check_output(1, K_DISP, 32'h0, "t6_rst_disp");
    check_output(1, K_SWAP, 32'h0, "t6_rst_swap");
    check_output(1, K_REPEAT, 32'h0, "t6_rst_repeat");
    apply_stimulus(0, 0, 0, 0, 1, 8'd0);
    apply_stimulus(0, 0, 0, 0, 0, 8'd0);
    rst = 1'b1;
    check_output(1, K_FRONT, 32'h0, "t6_no_swap_front");
    check_output(1, K_REPEAT, 32'h0, "t6_no_repeat");
    check_output(1, K_WR_READY, 32'h1, "t6_idle_wr_ready");
    apply_stimulus(0, 0, 0, 0, 1, 8'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, 0, 8'd0);

    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      total_cnt = total_cnt + 1;
      $display("[TB] FAIL %s: got no sample, want 0x%0h", c.name, c.exp);
    end
    while (swap_q.size() > 0) begin
      logic f;
      f = swap_q.pop_front();
      total_cnt = total_cnt + 1;
      $display("[TB] FAIL missing_swap: got no swap, want swap to front_sel=%0b", f);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
